// File: rtl/mult_div_pkg.sv
// rtl/mult_div_pkg.sv - shared encodings and constants for the HI/LO multiply/divide unit
package mult_div_pkg;

   localparam int ITERATIONS = 32;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_CALC     = 3'd1,
      ST_FIXUP    = 3'd2,
      ST_WRITE_LO = 3'd3,
      ST_WRITE_HI = 3'd4
   } state_e;

   // Two's-complement magnitude when the operand is treated as negative.
   function automatic logic [31:0] magnitude(input logic [31:0] value, input logic negative);
      return negative ? (~value + 32'd1) : value;
   endfunction

endpackage

// File: rtl/hi_lo_mult_div_if.sv
// rtl/hi_lo_mult_div_if.sv - operand request and HI/LO write bundle for the multiply/divide unit
interface hi_lo_mult_div_if;

   logic        start;
   logic [1:0]  op;
   logic [31:0] rs_value;
   logic [31:0] rt_value;
   logic        busy;
   logic [31:0] LO_input;
   logic [31:0] HI_input;
   logic        LO_write_enable;
   logic        HI_write_enable;

   // Control path / operand bus side.
   modport master (
      output start, op, rs_value, rt_value,
      input  busy, LO_input, HI_input, LO_write_enable, HI_write_enable
   );

   // Multiply/divide unit side.
   modport slave (
      input  start, op, rs_value, rt_value,
      output busy, LO_input, HI_input, LO_write_enable, HI_write_enable
   );

endinterface

// File: rtl/hi_lo_mult_div.sv
// rtl/hi_lo_mult_div.sv - iterative MULT/MULTU/DIV/DIVU unit feeding the HI/LO register file
module hi_lo_mult_div
   import mult_div_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             clk_enable,
   hi_lo_mult_div_if.slave  bus
);

   localparam logic [5:0] LAST_ITER = 6'(ITERATIONS - 1);

   state_e      state;
   logic [5:0]  count;
   logic [63:0] acc;        // multiply: {partial product, multiplier}; divide: {remainder, quotient}
   logic [31:0] operand;    // multiplicand or divisor magnitude
   logic        is_div;
   logic        neg_lo;     // negate LO (or whole product for multiply) in FIXUP
   logic        neg_hi;     // negate HI (remainder) in FIXUP for divide
   logic [31:0] lo_result;
   logic [31:0] hi_result;

   op_e         op_sel;
   logic        start_div;
   logic        start_signed;
   logic        rs_neg;
   logic        rt_neg;
   logic [31:0] rs_mag;
   logic [31:0] rt_mag;
   logic        div_by_zero;

   logic [32:0] mul_sum;
   logic [63:0] mul_next;
   logic [32:0] div_shift;
   logic [32:0] div_diff;
   logic [63:0] div_next;
   logic [63:0] iter_next;

   logic [63:0] prod_fixed;
   logic [31:0] lo_fixed;
   logic [31:0] hi_fixed;

   // Decode the incoming request: operand class, signs and magnitudes.
   always_comb begin
      op_sel       = op_e'(bus.op);
      start_div    = (op_sel == OP_DIV) || (op_sel == OP_DIVU);
      start_signed = (op_sel == OP_MULT) || (op_sel == OP_DIV);
      rs_neg       = start_signed & bus.rs_value[31];
      rt_neg       = start_signed & bus.rt_value[31];
      rs_mag       = magnitude(bus.rs_value, rs_neg);
      rt_mag       = magnitude(bus.rt_value, rt_neg);
      div_by_zero  = start_div && (bus.rt_value == 32'd0);
   end

   // One shift-add or restoring-division step on the accumulator.
   always_comb begin
      mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, operand} : 33'd0);
      mul_next  = {mul_sum, acc[31:1]};
      // Partial remainder is always below 2*divisor, so 33 bits hold the shift and its
      // difference; bit 32 of the difference set means the trial subtraction went negative.
      div_shift = {acc[63:32], acc[31]};
      div_diff  = div_shift - {1'b0, operand};
      div_next  = div_diff[32] ? {div_shift[31:0], acc[30:0], 1'b0}
                               : {div_diff[31:0],  acc[30:0], 1'b1};
      iter_next = is_div ? div_next : mul_next;
   end

   // Sign correction applied on the way out of FIXUP.
   always_comb begin
      prod_fixed = neg_lo ? (~acc + 64'd1) : acc;
      if (is_div) begin
         lo_fixed = neg_lo ? (~acc[31:0] + 32'd1) : acc[31:0];
         hi_fixed = neg_hi ? (~acc[63:32] + 32'd1) : acc[63:32];
      end else begin
         lo_fixed = prod_fixed[31:0];
         hi_fixed = prod_fixed[63:32];
      end
   end

   // Control FSM and datapath registers; everything freezes while clk_enable is low.
   always_ff @(posedge clk) begin
      if (clk_enable) begin
         if (reset) begin
            state     <= ST_IDLE;
            count     <= '0;
            acc       <= '0;
            operand   <= '0;
            is_div    <= 1'b0;
            neg_lo    <= 1'b0;
            neg_hi    <= 1'b0;
            lo_result <= '0;
            hi_result <= '0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (bus.start) begin
                     is_div <= start_div;
                     count  <= '0;
                     if (start_div) begin
                        operand <= rt_mag;
                        neg_lo  <= rs_neg ^ rt_neg;
                        neg_hi  <= rs_neg;
                     end else begin
                        operand <= rs_mag;
                        neg_lo  <= rs_neg ^ rt_neg;
                        neg_hi  <= rs_neg ^ rt_neg;
                     end
                     if (div_by_zero) begin
                        acc       <= '0;
                        lo_result <= 32'hFFFF_FFFF;
                        hi_result <= bus.rs_value;
                        state     <= ST_WRITE_LO;
                     end else begin
                        acc   <= start_div ? {32'd0, rs_mag} : {32'd0, rt_mag};
                        state <= ST_CALC;
                     end
                  end
               end
               ST_CALC: begin
                  acc   <= iter_next;
                  count <= count + 6'd1;
                  if (count == LAST_ITER) begin
                     state <= ST_FIXUP;
                  end
               end
               ST_FIXUP: begin
                  lo_result <= lo_fixed;
                  hi_result <= hi_fixed;
                  state     <= ST_WRITE_LO;
               end
               ST_WRITE_LO: begin
                  state <= ST_WRITE_HI;
               end
               ST_WRITE_HI: begin
                  state <= ST_IDLE;
               end
               default: begin
                  state <= ST_IDLE;
               end
            endcase
         end
      end
   end

   // Status and write strobes decoded from the registered state.
   always_comb begin
      bus.busy            = (state != ST_IDLE);
      bus.LO_input        = lo_result;
      bus.HI_input        = hi_result;
      bus.LO_write_enable = (state == ST_WRITE_LO) && clk_enable;
      bus.HI_write_enable = (state == ST_WRITE_HI) && clk_enable;
   end

endmodule

// File: tb/tb_hi_lo_mult_div.sv
// tb/tb_hi_lo_mult_div.sv - directed self-checking bench for hi_lo_mult_div
module tb_hi_lo_mult_div;

   logic clk = 1'b0;
   logic reset;
   logic clk_enable;

   hi_lo_mult_div_if bus();

   hi_lo_mult_div dut (
      .clk        (clk),
      .reset      (reset),
      .clk_enable (clk_enable),
      .bus        (bus)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Issue one request, then watch it cycle by cycle (cyc 0 = negedge after the accept edge).
   task automatic run_op(input string tag, input logic [1:0] o,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                         input int exp_lo_cyc, input int exp_hi_cyc, input int exp_idle_cyc,
                         input int stall_at, input int stall_len, input int poke_cyc);
      int lo_cnt = 0;
      int hi_cnt = 0;
      int lo_cyc = -1;
      int hi_cyc = -1;
      int idle_cyc = -1;
      int bad = 0;
      logic [31:0] lo_val = '0;
      logic [31:0] hi_val = '0;
      @(negedge clk);
      bus.start = 1'b1; bus.op = o; bus.rs_value = a; bus.rt_value = b;
      @(negedge clk);
      bus.start = 1'b0; bus.op = 2'b10;
      bus.rs_value = $urandom; bus.rt_value = $urandom;
      for (int cyc = 0; cyc < 80 && idle_cyc < 0; cyc++) begin
         if (cyc > 0) @(negedge clk);
         if (cyc == stall_at) clk_enable = 1'b0;
         if (cyc == stall_at + stall_len) clk_enable = 1'b1;
         if (cyc == poke_cyc) begin
            bus.start = 1'b1; bus.op = 2'b11; bus.rs_value = 32'd9; bus.rt_value = 32'd0;
         end else begin
            bus.start = 1'b0;
         end
         #1;
         if (!clk_enable && (bus.LO_write_enable || bus.HI_write_enable)) bad++;
         if (bus.LO_write_enable && bus.HI_write_enable) bad++;
         if (bus.LO_write_enable) begin lo_cnt++; lo_cyc = cyc; lo_val = bus.LO_input; end
         if (bus.HI_write_enable) begin hi_cnt++; hi_cyc = cyc; hi_val = bus.HI_input; end
         if (!bus.busy) idle_cyc = cyc;
      end
      bus.start = 1'b0;
      clk_enable = 1'b1;
      check($sformatf("%s lo_strobe_count", tag), lo_cnt, 1);
      check($sformatf("%s hi_strobe_count", tag), hi_cnt, 1);
      check($sformatf("%s lo_strobe_cycle", tag), lo_cyc, exp_lo_cyc);
      check($sformatf("%s hi_strobe_cycle", tag), hi_cyc, exp_hi_cyc);
      check($sformatf("%s idle_cycle", tag), idle_cyc, exp_idle_cyc);
      check($sformatf("%s lo_at_strobe", tag), lo_val, exp_lo);
      check($sformatf("%s hi_at_strobe", tag), hi_val, exp_hi);
      check($sformatf("%s bad_strobes", tag), bad, 0);
      check($sformatf("%s lo_held", tag), bus.LO_input, exp_lo);
      check($sformatf("%s hi_held", tag), bus.HI_input, exp_hi);
   endtask

   initial begin
      int strobes_seen;
      reset = 1'b1; clk_enable = 1'b1;
      bus.start = 1'b0; bus.op = 2'b00; bus.rs_value = '0; bus.rt_value = '0;
      repeat (2) @(negedge clk);
      #1;
      check("reset busy", bus.busy, 0);
      check("reset lo_input", bus.LO_input, 0);
      check("reset hi_input", bus.HI_input, 0);
      check("reset lo_we", bus.LO_write_enable, 0);
      check("reset hi_we", bus.HI_write_enable, 0);
      reset = 1'b0;

      run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 33, 34, 35, -1, 0, -1);
      run_op("mult_neg3x7", 2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, 32'hFFFF_FFFF, 33, 34, 35, -1, 0, -1);
      run_op("mult_min_sq", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 32'h4000_0000, 33, 34, 35, -1, 0, -1);
      run_op("div_neg7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33, 34, 35, -1, 0, -1);
      run_op("divu_7_2", 2'b11, 32'd7, 32'd2, 32'd3, 32'd1, 33, 34, 35, -1, 0, -1);
      run_op("div_overflow", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 33, 34, 35, -1, 0, -1);
      run_op("div_100_neg7", 2'b10, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2, 33, 34, 35, -1, 0, -1);
      run_op("div_by_zero", 2'b10, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 0, 1, 2, -1, 0, -1);
      run_op("stall_calc", 2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 32'h0000_0001, 38, 39, 40, 10, 5, -1);
      run_op("stall_lo", 2'b11, 32'd100, 32'd7, 32'd14, 32'd2, 38, 39, 40, 33, 5, -1);
      run_op("start_busy", 2'b00, 32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 33, 34, 35, -1, 0, 4);

      // Reset sampled at E10 aborts the operation with no strobes and clears results.
      @(negedge clk);
      bus.start = 1'b1; bus.op = 2'b01; bus.rs_value = 32'd5; bus.rt_value = 32'd6;
      @(negedge clk);
      bus.start = 1'b0;
      strobes_seen = 0;
      for (int cyc = 1; cyc <= 9; cyc++) begin
         @(negedge clk);
         #1;
         if (bus.LO_write_enable || bus.HI_write_enable) strobes_seen++;
      end
      reset = 1'b1;
      @(negedge clk);
      #1;
      check("abort busy", bus.busy, 0);
      check("abort lo_input", bus.LO_input, 0);
      check("abort hi_input", bus.HI_input, 0);
      reset = 1'b0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         @(negedge clk);
         #1;
         if (bus.LO_write_enable || bus.HI_write_enable) strobes_seen++;
      end
      check("abort no_strobes", strobes_seen, 0);

      run_op("after_abort", 2'b11, 32'd100, 32'd10, 32'd10, 32'd0, 33, 34, 35, -1, 0, -1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
